bus_dump_serializer: RTL and testbench

Streams a captured snapshot of a wide parallel debug bus (MIPS register bank or data-memory contents) as a byte sequence into the UART TX FIFO, followed by a one-byte checksum. It sits between the MIPS core's flat content buses and the UART transmitter, on the debugger's dump path. It handles TX-FIFO backpressure, so the debugger only issues a start and waits for done.

---
 rtl/bus_dump_serializer.sv | 119 +++++++++++
 tb/tb_bus_dump_serializer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/bus_dump_serializer.sv
// Streams a captured snapshot of a wide debug bus into the UART TX FIFO, word 0
// first and MSB-first within each word, then appends a modulo-2^8 checksum byte.
module bus_dump_serializer #(
  parameter int unsigned UART_BUS_SIZE = 8,
  parameter int unsigned WORD_SIZE     = 32,
  parameter int unsigned DATA_BUS_SIZE = 1024
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_start,
  input  logic [DATA_BUS_SIZE-1:0] i_data,
  input  logic                     i_uart_full,
  output logic                     o_uart_wr,
  output logic [UART_BUS_SIZE-1:0] o_uart_data,
  output logic                     o_busy,
  output logic                     o_done
);

  localparam int unsigned BYTES_PER_WORD = WORD_SIZE / UART_BUS_SIZE;
  localparam int unsigned N_BYTES        = DATA_BUS_SIZE / UART_BUS_SIZE;
  localparam int unsigned IDX_W          = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_BYTES - 1);

  generate
    if ((WORD_SIZE == 0) || (WORD_SIZE % UART_BUS_SIZE != 0)) begin : g_bad_word
      $error("bus_dump_serializer: WORD_SIZE must be a non-zero multiple of UART_BUS_SIZE");
    end
    if (DATA_BUS_SIZE % WORD_SIZE != 0) begin : g_bad_bus
      $error("bus_dump_serializer: DATA_BUS_SIZE must be a multiple of WORD_SIZE");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_CKSUM,
    ST_DONE
  } state_t;

  state_t                   state;
  state_t                   state_next;
  logic [DATA_BUS_SIZE-1:0] snapshot;
  logic [IDX_W-1:0]         idx;
  logic [UART_BUS_SIZE-1:0] cksum;
  logic [UART_BUS_SIZE-1:0] payload;
  logic                     wr;

  // Stream order as a static byte table: entry k is byte k of the dump.
  logic [UART_BUS_SIZE-1:0] payload_bytes [N_BYTES];

  for (genvar k = 0; k < N_BYTES; k++) begin : g_byte_map
    localparam int unsigned W = k / BYTES_PER_WORD;
    localparam int unsigned B = k % BYTES_PER_WORD;
    assign payload_bytes[k] =
      snapshot[W*WORD_SIZE + WORD_SIZE - 1 - B*UART_BUS_SIZE -: UART_BUS_SIZE];
  end

  always_comb payload = payload_bytes[idx];

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    wr         = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (i_start) state_next = ST_SEND;
      end
      ST_SEND: begin
        wr = !i_uart_full;
        if (wr && (idx == LAST_IDX)) state_next = ST_CKSUM;
      end
      ST_CKSUM: begin
        wr = !i_uart_full;
        if (wr) state_next = ST_DONE;
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      snapshot <= '0;
      idx      <= '0;
      cksum    <= '0;
    end else if ((state == ST_IDLE) && i_start) begin
      snapshot <= i_data;
      idx      <= '0;
      cksum    <= '0;
    end else if ((state == ST_SEND) && wr) begin
      cksum <= cksum + payload;
      // Index saturates on the last byte; CKSUM does not look at it.
      if (idx != LAST_IDX) idx <= idx + 1'b1;
    end
  end

  always_comb begin
    o_uart_data = '0;
    unique case (state)
      ST_SEND:  o_uart_data = payload;
      ST_CKSUM: o_uart_data = cksum;
      default:  o_uart_data = '0;
    endcase
  end

  assign o_uart_wr = wr;
  assign o_busy    = (state != ST_IDLE);
  assign o_done    = (state == ST_DONE);

endmodule

// File: tb/tb_bus_dump_serializer.sv
// Directed bench for bus_dump_serializer: a table of dump records with
// hand-computed checksums and done cycles, plus reset/held-start sequences.
module tb_bus_dump_serializer;

  logic          clk;
  logic          rst;
  logic          start;
  logic [1023:0] data;
  logic          full;
  logic          uart_wr;
  logic [7:0]    uart_data;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;

  bus_dump_serializer #(
    .UART_BUS_SIZE(8),
    .WORD_SIZE(32),
    .DATA_BUS_SIZE(1024)
  ) dut (
    .i_clk(clk),
    .i_reset(rst),
    .i_start(start),
    .i_data(data),
    .i_uart_full(full),
    .o_uart_wr(uart_wr),
    .o_uart_data(uart_data),
    .o_busy(busy),
    .o_done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  // word0 sits at bits [31:0]; all other words carry 'rest'.
  // Full stalls cycles lo..hi; poke != 0 changes i_data and pulses start that cycle.
  typedef struct {
    logic [31:0] word0;
    logic [31:0] rest;
    int          lo;
    int          hi;
    int          poke;
    logic [7:0]  ck;
    int          done_c;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input logic [1023:0] d, input int k);
    return d[(k/4)*32 + 31 - 8*(k%4) -: 8];
  endfunction

  // Call at a falling edge; the next rising edge is edge 0 of the dump.
  task automatic run_dump(input int id, input vec_t v);
    logic [1023:0] d;
    int nwr;
    d = {{31{v.rest}}, v.word0};
    data  = d;
    start = 1'b1;
    full  = 1'b0;
    nwr   = 0;
    for (int c = 1; c <= v.done_c + 3; c++) begin
      @(negedge clk);
      start = (c == v.poke);
      if (c == v.poke) data = '1;
      full = (c >= v.lo) && (c <= v.hi);
      #1;
      if (full) chk($sformatf("vec%0d c%0d stall wr", id, c), 32'(uart_wr), 32'd0);
      if (uart_wr) begin
        if (nwr < 128)
          chk($sformatf("vec%0d byte%0d", id, nwr), 32'(uart_data), 32'(exp_byte(d, nwr)));
        else if (nwr == 128)
          chk($sformatf("vec%0d cksum", id), 32'(uart_data), 32'(v.ck));
        else
          chk($sformatf("vec%0d extra write c%0d", id, c), 32'(nwr), 32'd128);
        nwr++;
      end
      chk($sformatf("vec%0d c%0d busy", id, c), 32'(busy), 32'(c <= v.done_c));
      chk($sformatf("vec%0d c%0d done", id, c), 32'(done), 32'(c == v.done_c));
    end
    chk($sformatf("vec%0d write count", id), 32'(nwr), 32'd129);
  endtask

  initial begin
    vecs[0] = '{32'h01020304, 32'h01020304, 0,   -1,  0, 8'h40, 130};
    vecs[1] = '{32'h01020304, 32'h01020304, 5,   14,  0, 8'h40, 140};
    vecs[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 0,   -1,  0, 8'h80, 130};
    vecs[3] = '{32'h00000001, 32'h00000001, 0,   -1,  0, 8'h20, 130};
    vecs[4] = '{32'h12345678, 32'h12345678, 1,   1,   0, 8'h80, 131};
    vecs[5] = '{32'h01020304, 32'h01020304, 128, 128, 0, 8'h40, 131};
    vecs[6] = '{32'h01020304, 32'h01020304, 129, 131, 0, 8'h40, 133};
    vecs[7] = '{32'hDEADBEEF, 32'h00000000, 0,   -1,  3, 8'h38, 130};

    // Reset held with start high: everything quiet.
    rst   = 1'b1;
    start = 1'b1;
    full  = 1'b0;
    data  = {32{32'h01020304}};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk($sformatf("reset%0d wr", i),   32'(uart_wr),   32'd0);
      chk($sformatf("reset%0d data", i), 32'(uart_data), 32'd0);
      chk($sformatf("reset%0d busy", i), 32'(busy),      32'd0);
      chk($sformatf("reset%0d done", i), 32'(done),      32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    run_dump(0, vecs[0]);

    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      run_dump(i, vecs[i]);
    end

    // Held start: two dumps with exactly one idle cycle between them.
    begin
      int nwr;
      int pos;
      nwr = 0;
      @(negedge clk);
      data  = {32{32'h01020304}};
      start = 1'b1;
      full  = 1'b0;
      for (int c = 1; c <= 262; c++) begin
        @(negedge clk);
        if (c == 262) start = 1'b0;
        #1;
        if (uart_wr) begin
          pos = nwr % 129;
          if (pos == 128) chk($sformatf("hold cksum%0d", nwr / 129), 32'(uart_data), 32'h40);
          else            chk($sformatf("hold byte%0d", nwr), 32'(uart_data), 32'(exp_byte(data, pos)));
          nwr++;
        end
        chk($sformatf("hold c%0d done", c), 32'(done), 32'((c == 130) || (c == 261)));
        chk($sformatf("hold c%0d busy", c), 32'(busy), 32'((c != 131) && (c != 262)));
        if (c == 132) chk("hold restart wr", 32'(uart_wr), 32'd1);
      end
      chk("hold write count", 32'(nwr), 32'd258);
    end

    // Reset after 50 writes truncates; the next dump restarts cleanly.
    begin
      int nwr;
      nwr = 0;
      @(negedge clk);
      data  = {32{32'hFFFFFFFF}};
      start = 1'b1;
      full  = 1'b0;
      for (int c = 1; c <= 50; c++) begin
        @(negedge clk);
        start = 1'b0;
        #1;
        if (uart_wr) nwr++;
      end
      chk("abort writes before reset", 32'(nwr), 32'd50);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("abort wr",   32'(uart_wr),   32'd0);
      chk("abort data", 32'(uart_data), 32'd0);
      chk("abort busy", 32'(busy),      32'd0);
      chk("abort done", 32'(done),      32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      run_dump(8, vecs[0]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
